// File: rtl/tpu_pkg.sv
// Shared TPU definitions: default datapath widths, the result-drain state
// encoding and a helper that turns FIFO flags into an occupancy count.
package tpu_pkg;

  localparam int TPU_ADDR_W  = 13;
  localparam int TPU_DATA_W  = 8;
  // Wide enough to count 255 elements and still reach the terminal value.
  localparam int DRAIN_CNT_W = 9;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } drain_state_t;

  function automatic logic [1:0] fifo_level(input logic full, input logic empty);
    return full ? 2'd2 : (empty ? 2'd0 : 2'd1);
  endfunction

endpackage

// File: rtl/sync_fifo2.sv
// Two-entry synchronous FIFO holding unified-buffer read data until the host
// stream accepts it. Reads return zero when empty.
module sync_fifo2 #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] pop_data,
  output logic              full,
  output logic              empty
);

  logic [DATA_W-1:0] mem0;
  logic [DATA_W-1:0] mem1;
  logic              wr_ptr;
  logic              rd_ptr;
  logic [1:0]        level;
  logic              do_push;
  logic              do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (!reset) begin
      mem0   <= '0;
      mem1   <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      level  <= 2'd0;
    end else begin
      if (do_push) begin
        if (wr_ptr) begin
          mem1 <= push_data;
        end else begin
          mem0 <= push_data;
        end
        wr_ptr <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({do_push, do_pop})
        2'b10:   level <= level + 2'd1;
        2'b01:   level <= level - 2'd1;
        default: level <= level;
      endcase
    end
  end

  assign full     = (level == 2'd2);
  assign empty    = (level == 2'd0);
  assign pop_data = empty ? '0 : (rd_ptr ? mem1 : mem0);

endmodule

// File: rtl/result_streamer.sv
// Drains one result block from the unified buffer onto the host stream,
// keeping at most two elements (buffered plus in flight) outstanding.
module result_streamer
  import tpu_pkg::*;
#(
  parameter int ADDR_W  = TPU_ADDR_W,
  parameter int DATA_W  = TPU_DATA_W,
  parameter int N_ELEMS = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_drain,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  output logic              busy,
  output logic              done
);

  localparam logic [DRAIN_CNT_W-1:0] NUM_ELEMS = DRAIN_CNT_W'(N_ELEMS);
  localparam logic [DRAIN_CNT_W-1:0] LAST_IDX  = DRAIN_CNT_W'(N_ELEMS - 1);

  drain_state_t            state;
  logic [ADDR_W-1:0]       next_addr;
  logic [DRAIN_CNT_W-1:0]  rd_cnt;
  logic [DRAIN_CNT_W-1:0]  out_cnt;
  logic                    rd_pend;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic                    issue;
  logic                    pop;
  logic [2:0]              used_after_pop;

  sync_fifo2 #(
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (rd_pend),
    .push_data (rd_data),
    .pop       (pop),
    .pop_data  (m_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign m_valid = !fifo_empty;
  assign pop     = m_valid && m_ready;
  assign m_last  = m_valid && (out_cnt == LAST_IDX);

  // An entry leaving this cycle frees its slot, which is what lets the
  // two-entry budget keep up with one element per cycle.
  assign used_after_pop = {1'b0, fifo_level(fifo_full, fifo_empty)}
                        + {2'b00, rd_pend} - {2'b00, pop};

  assign issue   = reset && (state == STREAM) && (rd_cnt < NUM_ELEMS)
                && (used_after_pop < 3'd2);
  assign rd_en   = issue;
  assign rd_addr = issue ? next_addr : '0;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      next_addr <= '0;
      rd_cnt    <= '0;
      out_cnt   <= '0;
      rd_pend   <= 1'b0;
    end else begin
      rd_pend <= issue;
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start_drain) begin
            state     <= STREAM;
            busy      <= 1'b1;
            next_addr <= base_addr;
            rd_cnt    <= '0;
            out_cnt   <= '0;
          end
        end
        STREAM: begin
          if (issue) begin
            next_addr <= next_addr + 1'b1;
            rd_cnt    <= rd_cnt + 1'b1;
          end
          if (pop) begin
            out_cnt <= out_cnt + 1'b1;
          end
          if (pop && m_last) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_result_streamer.sv
// Self-checking bench for result_streamer: a unified-buffer model answers
// reads, and per-scenario tasks compare the stream against a scoreboard.
module tb_result_streamer;

  localparam int AW = 13;
  localparam int DW = 8;
  localparam int N  = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          start_drain;
  logic [AW-1:0] base_addr;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic          busy;
  logic          done;

  logic [DW-1:0] ub [0:(1<<AW)-1];

  logic [AW-1:0] exp_addr_q [$];
  logic [AW-1:0] obs_addr_q [$];
  logic [DW-1:0] exp_data_q [$];
  logic [DW-1:0] obs_data_q [$];
  logic          exp_last_q [$];
  logic          obs_last_q [$];
  int            obs_cyc_q  [$];

  int tests_run;
  int tests_failed;
  int cyc;
  int rd_count;
  int valid_cycles;
  int done_pulses;
  int done_busy_bad;
  int idle_addr_bad;
  int stall_bad;
  int first_rd;
  int first_valid;
  logic          prev_stall;
  logic [DW-1:0] prev_data;
  logic          prev_last;

  result_streamer #(
    .ADDR_W  (AW),
    .DATA_W  (DW),
    .N_ELEMS (N)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start_drain (start_drain),
    .base_addr   (base_addr),
    .rd_en       (rd_en),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_data      (m_data),
    .m_last      (m_last),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  // Unified buffer: data appears one cycle after the read strobe.
  always @(posedge clk) begin
    rd_data <= rd_en ? ub[rd_addr] : '0;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: time limit reached, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic clear_obs();
    exp_addr_q.delete();
    obs_addr_q.delete();
    exp_data_q.delete();
    obs_data_q.delete();
    exp_last_q.delete();
    obs_last_q.delete();
    obs_cyc_q.delete();
    rd_count      = 0;
    valid_cycles  = 0;
    done_pulses   = 0;
    done_busy_bad = 0;
    idle_addr_bad = 0;
    stall_bad     = 0;
    first_rd      = -1;
    first_valid   = -1;
    prev_stall    = 1'b0;
  endtask

  task automatic push_expected(input logic [AW-1:0] base);
    logic [AW-1:0] a;
    for (int i = 0; i < N; i++) begin
      a = base + AW'(i);
      exp_addr_q.push_back(a);
      exp_data_q.push_back(ub[a]);
      exp_last_q.push_back(i == N - 1);
    end
  endtask

  // Records the current cycle (inputs already driven), then moves to the next negedge.
  task automatic tick();
    #1;
    if (reset) begin
      if (rd_en) begin
        obs_addr_q.push_back(rd_addr);
        rd_count++;
        if (first_rd < 0) first_rd = cyc;
      end else if (rd_addr !== '0) begin
        idle_addr_bad++;
      end
      if (m_valid) begin
        valid_cycles++;
        if (first_valid < 0) first_valid = cyc;
      end
      if (m_valid && m_ready) begin
        obs_data_q.push_back(m_data);
        obs_last_q.push_back(m_last);
        obs_cyc_q.push_back(cyc);
      end
      if (prev_stall && (m_valid !== 1'b1 || m_data !== prev_data || m_last !== prev_last))
        stall_bad++;
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      prev_last  = m_last;
      if (done) begin
        done_pulses++;
        if (busy) done_busy_bad++;
      end
    end else begin
      prev_stall = 1'b0;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0; start_drain = 1'b0; m_ready = 1'b0; base_addr = '0;
    tick();
    tick();
    tests_run++;
    if ({rd_en, rd_addr, m_valid, m_data, m_last, busy, done} !== '0) begin
      tests_failed++;
      $display("[TB] FAIL reset_outputs: got %h, expected 0",
               {rd_en, rd_addr, m_valid, m_data, m_last, busy, done});
    end
    reset = 1'b1;
    tick();
    tests_run++;
    if ({rd_en, rd_addr, m_valid, m_data, m_last, busy, done} !== '0) begin
      tests_failed++;
      $display("[TB] FAIL reset_first_cycle: got %h, expected 0",
               {rd_en, rd_addr, m_valid, m_data, m_last, busy, done});
    end
  endtask

  task automatic test_basic();
    logic [AW-1:0] ea, oa;
    logic [DW-1:0] ed, od;
    logic el, ol;
    int n, i, oc, c0;
    clear_obs();
    m_ready = 1'b1; base_addr = 13'h010; start_drain = 1'b1;
    push_expected(13'h010);
    tick();
    start_drain = 1'b0;
    tests_run++;
    if (busy !== 1'b1 || rd_en !== 1'b1 || rd_addr !== 13'h010) begin
      tests_failed++;
      $display("[TB] FAIL basic_first_read: got busy=%b rd_en=%b rd_addr=%h, expected 1 1 010",
               busy, rd_en, rd_addr);
    end
    n = 0;
    while (done_pulses == 0 && n < 40) begin tick(); n++; end
    repeat (4) tick();
    while (exp_addr_q.size() > 0) begin
      ea = exp_addr_q.pop_front();
      tests_run++;
      if (obs_addr_q.size() == 0) begin
        tests_failed++;
        $display("[TB] FAIL basic_rd_addr: got no read, expected %h", ea);
      end else begin
        oa = obs_addr_q.pop_front();
        if (oa !== ea) begin
          tests_failed++;
          $display("[TB] FAIL basic_rd_addr: got %h, expected %h", oa, ea);
        end
      end
    end
    tests_run++;
    if (obs_addr_q.size() != 0) begin
      tests_failed++;
      $display("[TB] FAIL basic_extra_reads: got %0d extra, expected 0", obs_addr_q.size());
    end
    i = 0; c0 = 0;
    while (exp_data_q.size() > 0) begin
      ed = exp_data_q.pop_front();
      el = exp_last_q.pop_front();
      tests_run++;
      if (obs_data_q.size() == 0) begin
        tests_failed++;
        $display("[TB] FAIL basic_elem%0d: got nothing, expected data=%0d last=%b", i, ed, el);
      end else begin
        od = obs_data_q.pop_front();
        ol = obs_last_q.pop_front();
        oc = obs_cyc_q.pop_front();
        if (i == 0) c0 = oc;
        if (od !== ed || ol !== el || oc != c0 + i) begin
          tests_failed++;
          $display("[TB] FAIL basic_elem%0d: got data=%0d last=%b offset=%0d, expected %0d %b %0d",
                   i, od, ol, oc - c0, ed, el, i);
        end
      end
      i++;
    end
    tests_run++;
    if (obs_data_q.size() != 0) begin
      tests_failed++;
      $display("[TB] FAIL basic_extra_elems: got %0d extra, expected 0", obs_data_q.size());
    end
    tests_run++;
    if (first_valid - first_rd != 2) begin
      tests_failed++;
      $display("[TB] FAIL basic_latency: got %0d cycles, expected 2", first_valid - first_rd);
    end
    tests_run++;
    if (done_pulses != 1 || done_busy_bad != 0) begin
      tests_failed++;
      $display("[TB] FAIL basic_done: got pulses=%0d busy_with_done=%0d, expected 1 0",
               done_pulses, done_busy_bad);
    end
    tests_run++;
    if (idle_addr_bad != 0) begin
      tests_failed++;
      $display("[TB] FAIL basic_idle_addr: got %0d nonzero cycles, expected 0", idle_addr_bad);
    end
  endtask

  task automatic test_stall();
    logic [AW-1:0] ea, oa;
    logic [DW-1:0] ed, od;
    logic el, ol;
    int n, i, hold_bad;
    clear_obs();
    m_ready = 1'b0; base_addr = 13'h010; start_drain = 1'b1;
    push_expected(13'h010);
    tick();
    start_drain = 1'b0;
    n = 0;
    while (m_valid !== 1'b1 && n < 10) begin tick(); n++; end
    hold_bad = 0;
    for (int k = 0; k < 5; k++) begin
      if (m_valid !== 1'b1 || m_data !== exp_data_q[0]) hold_bad++;
      tick();
    end
    tests_run++;
    if (hold_bad != 0) begin
      tests_failed++;
      $display("[TB] FAIL stall_hold: got %0d bad cycles (m_data=%0d), expected 0 with data %0d",
               hold_bad, m_data, exp_data_q[0]);
    end
    tests_run++;
    if (rd_count > 2) begin
      tests_failed++;
      $display("[TB] FAIL stall_reads: got %0d reads, expected at most 2", rd_count);
    end
    m_ready = 1'b1;
    n = 0;
    while (done_pulses == 0 && n < 40) begin tick(); n++; end
    repeat (4) tick();
    while (exp_addr_q.size() > 0) begin
      ea = exp_addr_q.pop_front();
      tests_run++;
      oa = (obs_addr_q.size() > 0) ? obs_addr_q.pop_front() : 'x;
      if (oa !== ea) begin
        tests_failed++;
        $display("[TB] FAIL stall_rd_addr: got %h, expected %h", oa, ea);
      end
    end
    i = 0;
    while (exp_data_q.size() > 0) begin
      ed = exp_data_q.pop_front();
      el = exp_last_q.pop_front();
      tests_run++;
      if (obs_data_q.size() == 0) begin
        tests_failed++;
        $display("[TB] FAIL stall_elem%0d: got nothing, expected data=%0d", i, ed);
      end else begin
        od = obs_data_q.pop_front();
        ol = obs_last_q.pop_front();
        if (od !== ed || ol !== el) begin
          tests_failed++;
          $display("[TB] FAIL stall_elem%0d: got data=%0d last=%b, expected %0d %b", i, od, ol, ed, el);
        end
      end
      i++;
    end
    tests_run++;
    if (obs_data_q.size() != 0 || obs_addr_q.size() != 0 || stall_bad != 0 || done_pulses != 1) begin
      tests_failed++;
      $display("[TB] FAIL stall_summary: got extra_elems=%0d extra_reads=%0d unstable=%0d done=%0d, expected 0 0 0 1",
               obs_data_q.size(), obs_addr_q.size(), stall_bad, done_pulses);
    end
  endtask

  task automatic test_wrap();
    logic [AW-1:0] ea, oa;
    logic [DW-1:0] ed, od;
    logic el, ol;
    int n;
    clear_obs();
    m_ready = 1'b1; base_addr = 13'h1FFE; start_drain = 1'b1;
    push_expected(13'h1FFE);
    tick();
    start_drain = 1'b0;
    n = 0;
    while (done_pulses == 0 && n < 100) begin
      m_ready = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    m_ready = 1'b1;
    repeat (4) tick();
    while (exp_addr_q.size() > 0) begin
      ea = exp_addr_q.pop_front();
      tests_run++;
      oa = (obs_addr_q.size() > 0) ? obs_addr_q.pop_front() : 'x;
      if (oa !== ea) begin
        tests_failed++;
        $display("[TB] FAIL wrap_rd_addr: got %h, expected %h", oa, ea);
      end
    end
    while (exp_data_q.size() > 0) begin
      ed = exp_data_q.pop_front();
      el = exp_last_q.pop_front();
      tests_run++;
      od = (obs_data_q.size() > 0) ? obs_data_q.pop_front() : 'x;
      ol = (obs_last_q.size() > 0) ? obs_last_q.pop_front() : 1'bx;
      if (od !== ed || ol !== el) begin
        tests_failed++;
        $display("[TB] FAIL wrap_elem: got data=%h last=%b, expected %h %b", od, ol, ed, el);
      end
    end
    tests_run++;
    if (obs_data_q.size() != 0 || stall_bad != 0 || done_pulses != 1) begin
      tests_failed++;
      $display("[TB] FAIL wrap_summary: got extra=%0d unstable=%0d done=%0d, expected 0 0 1",
               obs_data_q.size(), stall_bad, done_pulses);
    end
  endtask

  task automatic test_restart();
    logic [AW-1:0] ea, oa;
    logic [DW-1:0] ed, od;
    logic el, ol;
    int n;
    clear_obs();
    m_ready = 1'b1; base_addr = 13'h010; start_drain = 1'b1;
    push_expected(13'h010);
    tick();
    start_drain = 1'b0;
    tick();
    tick();
    base_addr = 13'h100; start_drain = 1'b1;
    tick();
    start_drain = 1'b0;
    n = 0;
    while (done_pulses == 0 && n < 40) begin tick(); n++; end
    repeat (6) tick();
    while (exp_addr_q.size() > 0) begin
      ea = exp_addr_q.pop_front();
      tests_run++;
      oa = (obs_addr_q.size() > 0) ? obs_addr_q.pop_front() : 'x;
      if (oa !== ea) begin
        tests_failed++;
        $display("[TB] FAIL restart_rd_addr: got %h, expected %h", oa, ea);
      end
    end
    while (exp_data_q.size() > 0) begin
      ed = exp_data_q.pop_front();
      el = exp_last_q.pop_front();
      tests_run++;
      od = (obs_data_q.size() > 0) ? obs_data_q.pop_front() : 'x;
      ol = (obs_last_q.size() > 0) ? obs_last_q.pop_front() : 1'bx;
      if (od !== ed || ol !== el) begin
        tests_failed++;
        $display("[TB] FAIL restart_elem: got data=%0d last=%b, expected %0d %b", od, ol, ed, el);
      end
    end
    tests_run++;
    if (obs_data_q.size() != 0 || obs_addr_q.size() != 0 || done_pulses != 1) begin
      tests_failed++;
      $display("[TB] FAIL restart_summary: got extra_elems=%0d extra_reads=%0d done=%0d, expected 0 0 1",
               obs_data_q.size(), obs_addr_q.size(), done_pulses);
    end
  endtask

  task automatic test_reset_mid();
    logic [AW-1:0] ea, oa;
    logic [DW-1:0] ed, od;
    logic el, ol;
    int n;
    clear_obs();
    m_ready = 1'b1; base_addr = 13'h010; start_drain = 1'b1;
    push_expected(13'h010);
    tick();
    start_drain = 1'b0;
    n = 0;
    while (obs_data_q.size() < 2 && n < 20) begin tick(); n++; end
    tests_run++;
    if (obs_data_q.size() < 2) begin
      tests_failed++;
      $display("[TB] FAIL midreset_setup: got %0d elements, expected 2", obs_data_q.size());
    end
    reset = 1'b0;
    tick();
    tests_run++;
    if ({rd_en, rd_addr, m_valid, m_data, m_last, busy, done} !== '0) begin
      tests_failed++;
      $display("[TB] FAIL midreset_outputs: got %h, expected 0",
               {rd_en, rd_addr, m_valid, m_data, m_last, busy, done});
    end
    reset = 1'b1;
    clear_obs();
    tick();
    tests_run++;
    if ({rd_en, rd_addr, m_valid, m_data, m_last, busy, done} !== '0) begin
      tests_failed++;
      $display("[TB] FAIL midreset_after: got %h, expected 0",
               {rd_en, rd_addr, m_valid, m_data, m_last, busy, done});
    end
    repeat (8) tick();
    tests_run++;
    if (valid_cycles != 0 || rd_count != 0 || done_pulses != 0) begin
      tests_failed++;
      $display("[TB] FAIL midreset_quiet: got valid=%0d reads=%0d done=%0d, expected 0 0 0",
               valid_cycles, rd_count, done_pulses);
    end
    clear_obs();
    base_addr = 13'h010; start_drain = 1'b1;
    push_expected(13'h010);
    tick();
    start_drain = 1'b0;
    n = 0;
    while (done_pulses == 0 && n < 40) begin tick(); n++; end
    repeat (4) tick();
    while (exp_addr_q.size() > 0) begin
      ea = exp_addr_q.pop_front();
      tests_run++;
      oa = (obs_addr_q.size() > 0) ? obs_addr_q.pop_front() : 'x;
      if (oa !== ea) begin
        tests_failed++;
        $display("[TB] FAIL midreset_rd_addr: got %h, expected %h", oa, ea);
      end
    end
    while (exp_data_q.size() > 0) begin
      ed = exp_data_q.pop_front();
      el = exp_last_q.pop_front();
      tests_run++;
      od = (obs_data_q.size() > 0) ? obs_data_q.pop_front() : 'x;
      ol = (obs_last_q.size() > 0) ? obs_last_q.pop_front() : 1'bx;
      if (od !== ed || ol !== el) begin
        tests_failed++;
        $display("[TB] FAIL midreset_elem: got data=%0d last=%b, expected %0d %b", od, ol, ed, el);
      end
    end
    tests_run++;
    if (obs_data_q.size() != 0 || done_pulses != 1) begin
      tests_failed++;
      $display("[TB] FAIL midreset_summary: got extra=%0d done=%0d, expected 0 1",
               obs_data_q.size(), done_pulses);
    end
  endtask

  initial begin
    reset = 1'b0; start_drain = 1'b0; m_ready = 1'b0; base_addr = '0;
    tests_run = 0; tests_failed = 0; cyc = 0;
    clear_obs();
    for (int i = 0; i < (1 << AW); i++) ub[i] = 8'(i ^ 32'h5A);
    ub[13'h010] = 8'd11;
    ub[13'h011] = 8'd22;
    ub[13'h012] = 8'd33;
    ub[13'h013] = 8'd44;
    ub[13'h1FFE] = 8'hA1;
    ub[13'h1FFF] = 8'hA2;
    ub[13'h0000] = 8'hA3;
    ub[13'h0001] = 8'hA4;
    @(negedge clk);
    test_reset();
    test_basic();
    test_stall();
    test_wrap();
    test_restart();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
